// File: rtl/spi_master_rx_multi.sv
// SPI master receive engine: deserialises 1/2/4-lane SDI into DATA_W-bit words
// and presents them through a registered valid/ready slot, gating the SPI clock on backpressure.
module spi_master_rx_multi #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              abort,
  input  logic              rx_edge,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [3:0]        sdi,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              rx_done,
  output logic              clk_en_o,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] LP_DW = IDX_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RECEIVE   = 2'd1,
    S_WAIT_FIFO = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // log2 of the lane count; the reserved mode 11 falls back to single lane
  function automatic logic [1:0] f_lane_shift(input logic [1:0] m);
    case (m)
      2'b01:   f_lane_shift = 2'd1;
      2'b10:   f_lane_shift = 2'd2;
      default: f_lane_shift = 2'd0;
    endcase
  endfunction

  state_t              r_state;
  logic [CNT_W-1:0]    r_target;
  logic [CNT_W-1:0]    r_tshifts;
  logic [1:0]          r_mode;
  logic                r_lsb;
  logic [DATA_W-1:0]   r_asm;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_total;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_done;

  logic [1:0]          w_lsh;
  logic [CNT_W-1:0]    w_in_target;
  logic [CNT_W-1:0]    w_in_tshifts;
  logic [IDX_W-1:0]    w_wshifts;
  logic [3:0]          w_lanes;
  logic [DATA_W-1:0]   w_lanes_ext;
  logic [IDX_W+1:0]    w_bitpos;
  logic [DATA_W-1:0]   w_asm_next;
  logic [IDX_W-1:0]    w_idx_next;
  logic [CNT_W-1:0]    w_tot_next;
  logic                w_final;
  logic                w_word_done;
  logic                w_slot_free;
  logic                w_capture;
  logic                w_stall;

  assign w_lsh        = f_lane_shift(r_mode);
  assign w_in_target  = counter_in_upd ? counter_in : r_target;
  assign w_in_tshifts = w_in_target >> f_lane_shift(mode);
  assign w_wshifts    = LP_DW >> w_lsh;

  always_comb begin
    w_lanes = 4'd0;
    case (w_lsh)
      2'd0:    w_lanes = {3'b000, sdi[0]};
      2'd1:    w_lanes = {2'b00, sdi[1:0]};
      default: w_lanes = sdi;
    endcase
  end

  assign w_lanes_ext = {{(DATA_W-4){1'b0}}, w_lanes};
  assign w_bitpos    = {2'b00, r_idx} << w_lsh;
  assign w_asm_next  = r_lsb ? (r_asm | (w_lanes_ext << w_bitpos))
                             : ((r_asm << (3'd1 << w_lsh)) | w_lanes_ext);
  assign w_idx_next  = r_idx + IDX_W'(1);
  assign w_tot_next  = r_total + CNT_W'(1);
  assign w_final     = (w_tot_next == r_tshifts);
  assign w_word_done = (w_idx_next == w_wshifts) || w_final;
  assign w_slot_free = !r_valid || data_ready;
  assign w_capture   = (r_state == S_RECEIVE) && rx_edge && !abort;
  // A completed word with nowhere to go must stop the SPI clock in the same cycle
  assign w_stall     = w_capture && w_word_done && !w_slot_free;

  assign clk_en_o   = (r_state == S_RECEIVE) && !abort && !w_stall;
  assign busy       = (r_state != S_IDLE);
  assign data       = r_data;
  assign data_valid = r_valid;
  assign rx_done    = r_done;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_target  <= CNT_W'(8);
      r_tshifts <= '0;
      r_mode    <= 2'b00;
      r_lsb     <= 1'b0;
      r_asm     <= '0;
      r_idx     <= '0;
      r_total   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_valid && data_ready) r_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (counter_in_upd) r_target <= counter_in;
          if (en) begin
            if (w_in_tshifts != '0) begin
              r_state   <= S_RECEIVE;
              r_mode    <= mode;
              r_lsb     <= lsb_first;
              r_tshifts <= w_in_tshifts;
              r_asm     <= '0;
              r_idx     <= '0;
              r_total   <= '0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end

        S_RECEIVE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_asm   <= '0;
          end else if (rx_edge) begin
            r_idx   <= w_idx_next;
            r_total <= w_tot_next;
            if (w_word_done && w_slot_free) begin
              r_data  <= w_asm_next;
              r_valid <= 1'b1;
              r_asm   <= '0;
              r_idx   <= '0;
              if (w_final) begin
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end else if (w_word_done) begin
              r_asm   <= w_asm_next;
              r_state <= w_final ? S_WAIT_DONE : S_WAIT_FIFO;
            end else begin
              r_asm <= w_asm_next;
            end
          end
        end

        S_WAIT_FIFO: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_asm   <= '0;
          end else if (w_slot_free) begin
            r_data  <= r_asm;
            r_valid <= 1'b1;
            r_asm   <= '0;
            r_idx   <= '0;
            r_state <= S_RECEIVE;
          end
        end

        S_WAIT_DONE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_asm   <= '0;
          end else if (w_slot_free) begin
            r_data  <= r_asm;
            r_valid <= 1'b1;
            r_done  <= 1'b1;
            r_asm   <= '0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
